// File: rtl/latch_write_seq.sv
// Write sequencer feeding a 3-to-8 latch-enable decoder: one accepted request
// becomes a setup / strobe / hold sequence on registered Addr, Data and en.
module latch_write_seq #(
  parameter int DW         = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [2:0]    Addr,
  output logic          en,
  output logic [DW-1:0] Data,
  output logic          busy,
  output logic          done
);

  localparam int MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_C  = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  typedef struct packed {
    logic [2:0]    addr;
    logic [DW-1:0] data;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign wr_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (wr_valid && wr_ready) begin
          req_d   = '{addr: wr_addr, data: wr_data};
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    en_d   = (state_d == STROBE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == HOLD) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Addr = req_q.addr;
  assign Data = req_q.data;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
